// File: rtl/tx_secuenciador_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tx_secuenciador_pkg
// Description : Shared state encoding, symbol constants and sizing helper
//               for the transmit-chain sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package tx_secuenciador_pkg;

    typedef enum logic [2:0] {
        ST_RST      = 3'd0,
        ST_PLL_WAIT = 3'd1,
        ST_PS_WAIT  = 3'd2,
        ST_TRAIN    = 3'd3,
        ST_IDLE     = 3'd4,
        ST_DATA     = 3'd5,
        ST_SKP      = 3'd6
    } state_t;

    localparam logic [7:0] c_COM = 8'hBC;
    localparam logic [7:0] c_SKP = 8'h1C;
    localparam logic [7:0] c_IDL = 8'h00;

    // COM followed by three SKP symbols
    localparam int c_SKP_LEN = 4;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_skp_timer.sv
`default_nettype none
// ============================================================================
// Module      : tx_skp_timer
// Description : SKP ordered-set interval counter with expiry flag.
//               Compiled only when SKP_INSERT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef SKP_INSERT_EN
module tx_skp_timer #(
    parameter int SKP_INTERVAL = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_count_en,
    input  logic i_restart,
    output logic o_expire
);

    localparam int c_W = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
    localparam logic [c_W-1:0] c_LAST = c_W'(SKP_INTERVAL - 1);

    logic [c_W-1:0] r_cnt;

    // Saturates at the last value so a late consumer still sees expiry
    always_ff @(posedge clk) begin
        if (rst || i_restart) begin
            r_cnt <= '0;
        end else if (i_count_en && (r_cnt != c_LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = (r_cnt == c_LAST);

endmodule
`endif
`default_nettype wire

// File: rtl/tx_secuenciador.sv
`default_nettype none
// ============================================================================
// Module      : tx_secuenciador
// Description : Transmit-chain sequencer: PLL/shifter bring-up, COM training,
//               payload gating. Define SKP_INSERT_EN for periodic SKP sets.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_secuenciador
    import tx_secuenciador_pkg::*;
#(
    parameter int PLL_LOCK_CYC = 16,
    parameter int PS_WAIT_CYC  = 4,
    parameter int TRAIN_LEN    = 8,
    parameter int SKP_INTERVAL = 64
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       DATA_VALID,
    output logic       TX_READY,
    output logic       RESET_PLL,
    output logic       RESET_PS,
    output logic       ENB_CONV,
    output logic       K,
    output logic       SYM_SEL,
    output logic [7:0] SYM,
    output logic       LINK_UP
);

    localparam int c_W_PLL = clog2_min1(PLL_LOCK_CYC);
    localparam int c_W_PS  = clog2_min1(PS_WAIT_CYC);
    localparam int c_W_TRN = clog2_min1(TRAIN_LEN);
    localparam int c_W_SKP = clog2_min1(c_SKP_LEN);
    localparam int c_W_A   = (c_W_PLL > c_W_PS)  ? c_W_PLL : c_W_PS;
    localparam int c_W_B   = (c_W_TRN > c_W_SKP) ? c_W_TRN : c_W_SKP;
    localparam int c_CNT_W = (c_W_A > c_W_B) ? c_W_A : c_W_B;

    localparam logic [c_CNT_W-1:0] c_PLL_LAST = c_CNT_W'(PLL_LOCK_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_PS_LAST  = c_CNT_W'(PS_WAIT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_TRN_LAST = c_CNT_W'(TRAIN_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_SKP_LAST = c_CNT_W'(c_SKP_LEN - 1);

    state_t             r_state;
    state_t             w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_counting;

    logic       r_tx_ready;
    logic       r_reset_pll;
    logic       r_reset_ps;
    logic       r_enb_conv;
    logic       r_k;
    logic       r_sym_sel;
    logic [7:0] r_sym;
    logic       r_link_up;

`ifdef SKP_INSERT_EN
    logic w_skp_due;

    tx_skp_timer #(
        .SKP_INTERVAL (SKP_INTERVAL)
    ) u_skp_timer (
        .clk        (CLK),
        .rst        (RESET),
        .i_count_en (r_link_up && (r_state != ST_SKP)),
        .i_restart  ((w_next == ST_SKP) && (r_state != ST_SKP)),
        .o_expire   (w_skp_due)
    );
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RST:      w_next = ST_PLL_WAIT;
            ST_PLL_WAIT: if (r_cnt == c_PLL_LAST) w_next = ST_PS_WAIT;
            ST_PS_WAIT:  if (r_cnt == c_PS_LAST)  w_next = ST_TRAIN;
            ST_TRAIN:    if (r_cnt == c_TRN_LAST) w_next = ST_IDLE;
            ST_IDLE: begin
`ifdef SKP_INSERT_EN
                if (w_skp_due) w_next = ST_SKP;
                else
`endif
                if (DATA_VALID) w_next = ST_DATA;
            end
            ST_DATA: begin
`ifdef SKP_INSERT_EN
                if (w_skp_due) w_next = ST_SKP;
                else
`endif
                if (!DATA_VALID) w_next = ST_IDLE;
            end
`ifdef SKP_INSERT_EN
            ST_SKP: if (r_cnt == c_SKP_LAST) w_next = DATA_VALID ? ST_DATA : ST_IDLE;
`endif
            default:     w_next = ST_RST;
        endcase
    end

    assign w_counting = (r_state inside {ST_PLL_WAIT, ST_PS_WAIT, ST_TRAIN, ST_SKP});

    // Outputs decode the state being entered, so they change on the entry edge
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_RST;
            r_cnt       <= '0;
            r_tx_ready  <= 1'b0;
            r_reset_pll <= 1'b1;
            r_reset_ps  <= 1'b1;
            r_enb_conv  <= 1'b0;
            r_k         <= 1'b0;
            r_sym_sel   <= 1'b1;
            r_sym       <= c_IDL;
            r_link_up   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_counting) begin
                r_cnt <= r_cnt + 1'b1;
            end

            r_reset_pll <= (w_next == ST_RST);
            r_reset_ps  <= (w_next inside {ST_RST, ST_PLL_WAIT});
            r_enb_conv  <= (w_next == ST_DATA);
            r_k         <= (w_next inside {ST_TRAIN, ST_SKP});
            r_sym_sel   <= (w_next != ST_DATA);
            r_tx_ready  <= (w_next inside {ST_IDLE, ST_DATA});
            r_link_up   <= r_link_up || (w_next == ST_IDLE);

            case (w_next)
                ST_TRAIN: r_sym <= c_COM;
                ST_SKP:   r_sym <= (r_state != ST_SKP) ? c_COM : c_SKP;
                default:  r_sym <= c_IDL;
            endcase
        end
    end

    assign TX_READY  = r_tx_ready;
    assign RESET_PLL = r_reset_pll;
    assign RESET_PS  = r_reset_ps;
    assign ENB_CONV  = r_enb_conv;
    assign K         = r_k;
    assign SYM_SEL   = r_sym_sel;
    assign SYM       = r_sym;
    assign LINK_UP   = r_link_up;

endmodule
`default_nettype wire

// File: tb/tb_tx_secuenciador.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_secuenciador
// Description : Self-checking bench for tx_secuenciador (default parameters);
//               SKP scenarios are exercised when SKP_INSERT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_secuenciador;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       DATA_VALID = 1'b0;
    logic       TX_READY;
    logic       RESET_PLL;
    logic       RESET_PS;
    logic       ENB_CONV;
    logic       K;
    logic       SYM_SEL;
    logic [7:0] SYM;
    logic       LINK_UP;

    tx_secuenciador dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .DATA_VALID (DATA_VALID),
        .TX_READY   (TX_READY),
        .RESET_PLL  (RESET_PLL),
        .RESET_PS   (RESET_PS),
        .ENB_CONV   (ENB_CONV),
        .K          (K),
        .SYM_SEL    (SYM_SEL),
        .SYM        (SYM),
        .LINK_UP    (LINK_UP)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       rst_pll;
        logic       rst_ps;
        logic       enb;
        logic       k;
        logic       sym_sel;
        logic [7:0] sym;
        logic       tx_ready;
        logic       link_up;
    } obs_t;

    typedef struct {
        obs_t exp;
        obs_t msk;
        int   cyc;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    localparam obs_t c_FULL     = '1;
    localparam obs_t c_DATA_MSK = 15'b111_11_00000000_11;

    function automatic obs_t mk(bit pll, bit ps, bit enb, bit k, bit sel,
                                logic [7:0] sym, bit rdy, bit lu);
        return {pll, ps, enb, k, sel, sym, rdy, lu};
    endfunction

    function automatic obs_t observed();
        return {RESET_PLL, RESET_PS, ENB_CONV, K, SYM_SEL, SYM, TX_READY, LINK_UP};
    endfunction

    // Expected outputs c cycles after RESET is released (defaults 16/4/8)
    function automatic obs_t exp_bringup(int c);
        bit k;
        k = (c >= 21) && (c <= 28);
        return mk(1'b0, c < 17, 1'b0, k, 1'b1, k ? 8'hBC : 8'h00, c >= 29, c >= 29);
    endfunction

    function automatic obs_t rst_obs();
        return mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    endfunction

    function automatic obs_t idle_obs();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    endfunction

    function automatic obs_t data_obs();
        return mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    endfunction

    function automatic obs_t skp_obs(logic [7:0] sym);
        return mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, sym, 1'b0, 1'b1);
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_next(obs_t e, obs_t m, int c);
        sb_q.push_back('{exp: e, msk: m, cyc: c});
    endtask

    // Leaves the DUT in IDLE, 29 cycles after reset release
    task automatic bring_up();
        RESET      = 1'b1;
        DATA_VALID = 1'b0;
        repeat (3) step();
        RESET = 1'b0;
        repeat (29) step();
    endtask

    task automatic test_reset();
        sb_t s;
        RESET      = 1'b1;
        DATA_VALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_next(rst_obs(), c_FULL, -3 + i);
            step();
            s = sb_q.pop_front();
            n_checks++;
            if (((observed() ^ s.exp) & s.msk) !== '0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", s.cyc, observed(), s.exp);
            end
        end
        RESET = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            expect_next(exp_bringup(c), c_FULL, c);
            step();
            s = sb_q.pop_front();
            n_checks++;
            if (((observed() ^ s.exp) & s.msk) !== '0) begin
                n_fail++;
                $display("FAIL bringup cyc=%0d got=%h exp=%h", s.cyc, observed(), s.exp);
            end
        end
    endtask

    task automatic test_data_burst();
        sb_t s;
        bring_up();
        for (int c = 1; c <= 13; c++) begin
            DATA_VALID = (c <= 10);
            if (c <= 10) expect_next(data_obs(), c_DATA_MSK, c);
            else         expect_next(idle_obs(), c_FULL, c);
            step();
            s = sb_q.pop_front();
            n_checks++;
            if (((observed() ^ s.exp) & s.msk) !== '0) begin
                n_fail++;
                $display("FAIL data_burst cyc=%0d got=%h exp=%h", s.cyc, observed(), s.exp);
            end
        end
    endtask

    // Continues from IDLE left by test_data_burst, well before any SKP
    task automatic test_back_to_back();
        sb_t s;
        bit  pat [10] = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 0};
        for (int i = 0; i < 10; i++) begin
            DATA_VALID = pat[i];
            if (pat[i]) expect_next(data_obs(), c_DATA_MSK, i);
            else        expect_next(idle_obs(), c_FULL, i);
            step();
            s = sb_q.pop_front();
            n_checks++;
            if (((observed() ^ s.exp) & s.msk) !== '0) begin
                n_fail++;
                $display("FAIL back_to_back idx=%0d got=%h exp=%h", s.cyc, observed(), s.exp);
            end
        end
        DATA_VALID = 1'b0;
    endtask

`ifdef SKP_INSERT_EN
    task automatic test_skp_data();
        sb_t s;
        int  o;
        bring_up();
        DATA_VALID = 1'b1;
        for (int c = 30; c <= 240; c++) begin
            o = c - 93;
            if (c >= 93 && (o % 68) < 4)
                expect_next(skp_obs((o % 68 == 0) ? 8'hBC : 8'h1C), c_FULL, c);
            else
                expect_next(data_obs(), c_DATA_MSK, c);
            step();
            s = sb_q.pop_front();
            n_checks++;
            if (((observed() ^ s.exp) & s.msk) !== '0) begin
                n_fail++;
                $display("FAIL skp_data cyc=%0d got=%h exp=%h", s.cyc, observed(), s.exp);
            end
        end
        DATA_VALID = 1'b0;
    endtask

    task automatic test_simultaneous();
        sb_t s;
        bring_up();
        for (int c = 30; c <= 100; c++) begin
            DATA_VALID = (c < 93);
            if (c < 93)      expect_next(data_obs(), c_DATA_MSK, c);
            else if (c < 97) expect_next(skp_obs((c == 93) ? 8'hBC : 8'h1C), c_FULL, c);
            else             expect_next(idle_obs(), c_FULL, c);
            step();
            s = sb_q.pop_front();
            n_checks++;
            if (((observed() ^ s.exp) & s.msk) !== '0) begin
                n_fail++;
                $display("FAIL simultaneous cyc=%0d got=%h exp=%h", s.cyc, observed(), s.exp);
            end
        end
    endtask
`else
    task automatic test_no_skp();
        sb_t s;
        bring_up();
        DATA_VALID = 1'b1;
        for (int c = 30; c < 530; c++) begin
            expect_next(data_obs(), c_DATA_MSK, c);
            step();
            s = sb_q.pop_front();
            n_checks++;
            if (((observed() ^ s.exp) & s.msk) !== '0) begin
                n_fail++;
                $display("FAIL no_skp cyc=%0d got=%h exp=%h", s.cyc, observed(), s.exp);
            end
        end
        DATA_VALID = 1'b0;
    endtask
`endif

    task automatic test_mid_reset();
        sb_t s;
        int  stop_cyc;
        bring_up();
        DATA_VALID = 1'b1;
`ifdef SKP_INSERT_EN
        stop_cyc = 94;  // second SKP symbol
`else
        stop_cyc = 40;
`endif
        for (int c = 30; c <= stop_cyc; c++) begin
`ifdef SKP_INSERT_EN
            if (c >= 93) expect_next(skp_obs((c == 93) ? 8'hBC : 8'h1C), c_FULL, c);
            else         expect_next(data_obs(), c_DATA_MSK, c);
`else
            expect_next(data_obs(), c_DATA_MSK, c);
`endif
            step();
            s = sb_q.pop_front();
            n_checks++;
            if (((observed() ^ s.exp) & s.msk) !== '0) begin
                n_fail++;
                $display("FAIL mid_reset_pre cyc=%0d got=%h exp=%h", s.cyc, observed(), s.exp);
            end
        end
        RESET = 1'b1;
        expect_next(rst_obs(), c_FULL, 0);
        step();
        s = sb_q.pop_front();
        n_checks++;
        if (((observed() ^ s.exp) & s.msk) !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_apply got=%h exp=%h", observed(), s.exp);
        end
        RESET      = 1'b0;
        DATA_VALID = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            expect_next(exp_bringup(c), c_FULL, c);
            step();
            s = sb_q.pop_front();
            n_checks++;
            if (((observed() ^ s.exp) & s.msk) !== '0) begin
                n_fail++;
                $display("FAIL mid_reset_rebringup cyc=%0d got=%h exp=%h", s.cyc, observed(), s.exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_data_burst();
        test_back_to_back();
`ifdef SKP_INSERT_EN
        test_skp_data();
        test_simultaneous();
`else
        test_no_skp();
`endif
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/tx_secuenciador.md
# tx_secuenciador

Transmit-side controller that sequences the serial transmit chain (PLL, byte converter, 8b/10b encoder, parallel-to-serial shifter). It owns PLL and shifter resets, runs a fixed bring-up and training sequence, then gates the byte converter for payload. Optionally it inserts periodic SKP ordered sets. It drives the encoder's K flag and a symbol-override mux that selects between converter bytes and controller-generated control symbols.

## Interface
Parameters:
- PLL_LOCK_CYC, 16: cycles RESET_PLL is held low before the shifter is released.
- PS_WAIT_CYC, 4: cycles after RESET_PS release before training starts.
- TRAIN_LEN, 8: number of COM (K28.5, 0xBC) symbols sent in training.
- SKP_INTERVAL, 64: cycles between SKP ordered sets (SKP_INSERT_EN only).

Ports:
- CLK  in  1  symbol clock.
- RESET  in  1  synchronous, active-high reset.
- DATA_VALID  in  1  upstream has payload for the converter.
- TX_READY  out  1  payload accepted this cycle when DATA_VALID and TX_READY are both high.
- RESET_PLL  out  1  PLL reset.
- RESET_PS  out  1  parallel-to-serial reset.
- ENB_CONV  out  1  converter enable.
- K  out  1  encoder control-symbol flag.
- SYM_SEL  out  1  1 = encoder takes SYM; 0 = encoder takes converter output.
- SYM  out  8  control symbol byte.
- LINK_UP  out  1  training complete.

## Operation
- All outputs are registered, Moore-decoded from next state, so outputs change on the clock edge that enters a state.
- Reset values: RESET_PLL=1, RESET_PS=1, ENB_CONV=0, K=0, SYM_SEL=1, SYM=0x00, TX_READY=0, LINK_UP=0. All counters are 0 and the state is RST.
- Assertion of RESET in any state returns to RST on the next edge, aborting any ordered set or data transfer.
- State sequence:
  - RST: on the first cycle with RESET low, go to PLL_WAIT.
  - PLL_WAIT: RESET_PLL=0, RESET_PS=1. After PLL_LOCK_CYC cycles, go to PS_WAIT.
  - PS_WAIT: RESET_PS=0, SYM=0x00, K=0. After PS_WAIT_CYC cycles, go to TRAIN.
  - TRAIN: SYM=0xBC, K=1, SYM_SEL=1. After TRAIN_LEN cycles, go to IDLE, and LINK_UP=1 from then on until reset.
  - IDLE: SYM=0x00, K=0, SYM_SEL=1, TX_READY=1. DATA_VALID=1 goes to DATA.
  - DATA: SYM_SEL=0, K=0, ENB_CONV=1, TX_READY=1. DATA_VALID=0 returns to IDLE.
  - SKP (SKP_INSERT_EN only): four cycles emitting 0xBC, 0x1C, 0x1C, 0x1C, all with K=1, SYM_SEL=1, TX_READY=0, ENB_CONV=0. Exit goes to DATA if DATA_VALID=1, otherwise to IDLE.
- ENB_CONV is high only in DATA. K is high only in TRAIN and SKP.
- Counters are sized with $clog2 of their parameter. Each cycle counter resets to 0 on every state entry.

## Timing
- RESET deasserted at edge 0:
  - PLL_WAIT is entered at edge 1.
  - RESET_PS falls at edge 1+PLL_LOCK_CYC.
  - The first COM appears at edge 1+PLL_LOCK_CYC+PS_WAIT_CYC.
  - LINK_UP rises TRAIN_LEN cycles later.
- From IDLE, DATA_VALID sampled high gives ENB_CONV=1 one cycle later.
- From DATA, DATA_VALID low gives ENB_CONV=0 one cycle later.
- SKP timer:
  - Counts only while LINK_UP=1.
  - Expiry in IDLE or DATA forces SKP on the next edge. SKP wins over a simultaneous DATA_VALID change.
  - The timer restarts at SKP entry.
  - The timer saturates and does not count during SKP.
- The timer cannot expire during TRAIN, because it is not counting before LINK_UP.

## Configuration
- SKP_INSERT_EN defined: the SKP state and interval timer are compiled in.
- SKP_INSERT_EN undefined:
  - No timer and no SKP state; SKP_INTERVAL is unused.
  - TX_READY stays high for as long as LINK_UP is high.

## Structure
- Shared package holds:
  - State encoding: RST, PLL_WAIT, PS_WAIT, TRAIN, IDLE, DATA, SKP.
  - Symbol constants: COM=0xBC, SKP=0x1C, IDL=0x00.
- One natural sub-module, tx_skp_timer: the interval counter with an expiry pulse, guarded by SKP_INSERT_EN.

## Test plan
- Reset and bring-up, defaults: hold RESET 3 cycles, then release.
  - RESET_PLL falls at cycle 1.
  - RESET_PS falls at cycle 17.
  - 0xBC with K=1 for cycles 21–28.
  - LINK_UP=1 at cycle 29.
- Data burst: DATA_VALID high for 10 cycles from IDLE.
  - ENB_CONV high for exactly 10 cycles, each 1 cycle delayed.
  - SYM_SEL=0 and K=0 throughout.
- SKP during data (macro on): continuous DATA_VALID.
  - Every 64 cycles: TX_READY=0 for 4 cycles.
  - Sequence 0xBC, 0x1C, 0x1C, 0x1C with K=1.
  - ENB_CONV resumes on the next cycle.
- Mid-operation reset: assert RESET during the second SKP symbol.
  - Next edge shows all reset values.
  - Bring-up restarts from PLL_WAIT.
- Macro off: 500 cycles of continuous DATA_VALID after LINK_UP.
  - TX_READY never low.
  - K never high.
- Simultaneous events (macro on): DATA_VALID falls on the SKP expiry cycle.
  - SKP is entered.
  - Exit goes to IDLE with SYM=0x00.
